// File: rtl/wavegen_pkg.sv
// Shared encodings and reset constants for the DDS waveform generator.
package wavegen_pkg;

  // Shape select encodings; 3'b101..3'b111 produce a zero output.
  typedef enum logic [2:0] {
    FUNC_SAW    = 3'd0,
    FUNC_SQUARE = 3'd1,
    FUNC_TRI    = 3'd2,
    FUNC_TRAP   = 3'd3,
    FUNC_SINE   = 3'd4
  } func_e;

  // Reset values; ftw resets to zero and amplitude to all-ones (unity gain).
  localparam logic [2:0] RST_FUNC    = FUNC_SAW;
  localparam logic       RST_PENDING = 1'b0;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine table, filled at elaboration, read combinationally.
module sine_quarter_lut #(
  parameter int unsigned W      = 8,
  parameter int unsigned LUT_AW = 6
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [W-2:0]      data
);

  localparam int unsigned Depth = 1 << LUT_AW;

  // round((2^(W-1)-1) * sin(pi/2 * (k+0.5)/Depth)); Taylor series keeps it tool-portable.
  function automatic logic [W-2:0] lut_entry(input int unsigned k);
    real x;
    real term;
    real sum;
    real scale;
    int  v;
    x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(Depth);
    term = x;
    sum  = x;
    for (int n = 1; n <= 9; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    scale = real'((1 << (W - 1)) - 1);
    v     = $rtoi(scale * sum + 0.5);
    return (W - 1)'(v);
  endfunction

  logic [W-2:0] rom [Depth];

  for (genvar k = 0; k < Depth; k++) begin : g_rom
    localparam logic [W-2:0] Val = lut_entry(k);
    assign rom[k] = Val;
  end

  assign data = rom[addr];

endmodule

// File: rtl/wavegen_dds.sv
// DDS waveform generator: phase accumulator, wrap-synchronised config, 2-stage shape/scale pipe.
module wavegen_dds
  import wavegen_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned LUT_AW = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_func,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic [W-1:0]     cfg_amp,
  output logic [W-1:0]     out,
  output logic             out_valid,
  output logic             wrap
);

  logic [ACC_W-1:0] acc_q;
  logic             wrap_q;
  logic [2:0]       func_act_q, func_sh_q;
  logic [ACC_W-1:0] ftw_act_q, ftw_sh_q;
  logic [W-1:0]     amp_act_q, amp_sh_q;
  logic             pending_q;

  logic [W-1:0]     raw_q, amp_s1_q, out_q;
  logic             v1_q, out_valid_q;

  logic [ACC_W:0]   acc_sum;
  logic             carry, apply, accept;

  assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign carry   = en & acc_sum[ACC_W];
  // A frozen accumulator never wraps, so pending config lands on the next edge instead.
  assign apply   = pending_q & (carry | ~en);
  assign accept  = cfg_valid & ~pending_q;

  // Phase accumulator and registered carry pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      if (en) acc_q <= acc_sum[ACC_W-1:0];
      wrap_q <= carry;
    end
  end

  // Config handshake: shadow on accept, promote to active on wrap (or idle edge).
  always_ff @(posedge clk) begin
    if (reset) begin
      func_act_q <= RST_FUNC;
      ftw_act_q  <= '0;
      amp_act_q  <= '1;
      func_sh_q  <= RST_FUNC;
      ftw_sh_q   <= '0;
      amp_sh_q   <= '1;
      pending_q  <= RST_PENDING;
    end else if (apply) begin
      func_act_q <= func_sh_q;
      ftw_act_q  <= ftw_sh_q;
      amp_act_q  <= amp_sh_q;
      pending_q  <= 1'b0;
    end else if (accept) begin
      func_sh_q <= cfg_func;
      ftw_sh_q  <= cfg_ftw;
      amp_sh_q  <= cfg_amp;
      pending_q <= 1'b1;
    end
  end

  logic [W-1:0]      phase, ph_x2, ph_x4, raw_d;
  logic [1:0]        quad;
  logic [LUT_AW-1:0] lut_addr;
  logic [W-2:0]      lut_data;

  assign phase    = acc_q[ACC_W-1 -: W];
  assign quad     = phase[W-1 -: 2];
  assign ph_x2    = phase << 1;
  assign ph_x4    = phase << 2;
  // Odd quadrants walk the quarter table backwards.
  assign lut_addr = quad[0] ? ~phase[W-3 -: LUT_AW] : phase[W-3 -: LUT_AW];

  sine_quarter_lut #(
    .W      (W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .addr (lut_addr),
    .data (lut_data)
  );

  // Shape decode from the active function and current phase; M - x is written as ~x.
  always_comb begin
    raw_d = '0;
    case (func_act_q)
      FUNC_SAW:    raw_d = phase;
      FUNC_SQUARE: raw_d = phase[W-1] ? '0 : '1;
      FUNC_TRI:    raw_d = phase[W-1] ? ~ph_x2 : ph_x2;
      FUNC_TRAP: begin
        case (quad)
          2'b00:   raw_d = ph_x4;
          2'b11:   raw_d = ~ph_x4;
          default: raw_d = '1;
        endcase
      end
      // Upper half: 2^(W-1)+LUT; lower half: 2^(W-1)-1-LUT.
      FUNC_SINE:   raw_d = quad[1] ? {1'b0, ~lut_data} : {1'b1, lut_data};
      default:     raw_d = '0;
    endcase
  end

  logic [2*W-1:0] prod;
  assign prod = {{W{1'b0}}, raw_q} * ({{W{1'b0}}, amp_s1_q} + {{(2*W-1){1'b0}}, 1'b1});

  // Pipeline: stage 1 holds raw shape with its amplitude, stage 2 holds the scaled sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q       <= '0;
      amp_s1_q    <= '1;
      v1_q        <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      raw_q       <= raw_d;
      amp_s1_q    <= amp_act_q;
      v1_q        <= en;
      out_q       <= prod[2*W-1:W];
      out_valid_q <= v1_q;
    end
  end

  assign cfg_ready = ~pending_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_wavegen_dds.sv
// Self-checking bench for wavegen_dds against a cycle-level behavioural model.
module tb_wavegen_dds;

  localparam real PI = 3.141592653589793;
  localparam int  NLIT = 18;

  logic        clk = 1'b0;
  logic        reset, en, cfg_valid;
  logic [2:0]  cfg_func;
  logic [15:0] cfg_ftw;
  logic [7:0]  cfg_amp;
  logic        cfg_ready;
  logic [7:0]  dut_out;
  logic        out_valid, wrap;

  always #5 clk = ~clk;

  wavegen_dds #(
    .W      (8),
    .ACC_W  (16),
    .LUT_AW (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_func  (cfg_func),
    .cfg_ftw   (cfg_ftw),
    .cfg_amp   (cfg_amp),
    .out       (dut_out),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got timeout, required event within bound at %0t", name, $time);
  endtask

  // Shapes straight from their arithmetic definitions on an 8-bit phase.
  function automatic int shape_ref(input int func, input int p);
    int  k;
    real l;
    case (func)
      0: return p;
      1: return (p < 128) ? 255 : 0;
      2: return (p < 128) ? 2 * p : 511 - 2 * p;
      3: return (p < 64) ? 4 * p : ((p < 192) ? 255 : 1023 - 4 * p);
      4: begin
        k = p % 64;
        if ((p / 64) % 2 == 1) k = 63 - k;
        l = 127.0 * $sin(PI / 2.0 * (real'(k) + 0.5) / 64.0);
        return (p < 128) ? 128 + $rtoi(l + 0.5) : 127 - $rtoi(l + 0.5);
      end
      default: return 0;
    endcase
  endfunction

  function automatic int sample_ref(input int func, input int amp, input int p);
    return (shape_ref(func, p) * (amp + 1)) / 256;
  endfunction

  typedef struct {
    bit v;
    int val;
    int func;
    int amp;
    int p;
  } samp_t;

  int    m_acc, m_ftw, m_func, m_amp;
  int    sh_ftw, sh_func, sh_amp;
  bit    m_pend, m_wrap;
  bit    m_live = 1'b0;
  samp_t s1, s2;

  // Model: accumulator, config apply rule, and the 2-cycle sample delay.
  always @(posedge clk) begin
    m_live <= 1'b1;
    if (reset) begin
      m_acc  <= 0;
      m_ftw  <= 0;
      m_func <= 0;
      m_amp  <= 255;
      m_pend <= 1'b0;
      m_wrap <= 1'b0;
      s1     <= '{v: 1'b0, val: 0, func: 0, amp: 255, p: 0};
      s2     <= '{v: 1'b0, val: 0, func: 0, amp: 255, p: 0};
    end else begin
      s1 <= '{v: en, val: sample_ref(m_func, m_amp, m_acc / 256), func: m_func, amp: m_amp,
              p: m_acc / 256};
      s2 <= s1;
      m_wrap <= en && (m_acc + m_ftw >= 65536);
      if (en) m_acc <= (m_acc + m_ftw) % 65536;
      if (m_pend && (!en || (m_acc + m_ftw >= 65536))) begin
        m_func <= sh_func;
        m_ftw  <= sh_ftw;
        m_amp  <= sh_amp;
        m_pend <= 1'b0;
      end else if (cfg_valid && !m_pend) begin
        sh_func <= int'(cfg_func);
        sh_ftw  <= int'(cfg_ftw);
        sh_amp  <= int'(cfg_amp);
        m_pend  <= 1'b1;
      end
    end
  end

  // Hand-computed points: func, amp, phase, expected output.
  int lit_f [NLIT] = '{2, 2, 2, 2, 3, 3, 3, 3, 3, 4, 4, 4, 4, 4, 1, 1, 0, 0};
  int lit_a [NLIT] = '{255, 255, 255, 255, 255, 255, 255, 255, 255,
                       255, 255, 255, 255, 255, 127, 127, 0, 255};
  int lit_p [NLIT] = '{0, 127, 128, 255, 63, 64, 192, 193, 255,
                       0, 63, 64, 128, 255, 0, 200, 255, 100};
  int lit_v [NLIT] = '{0, 254, 255, 1, 252, 255, 255, 251, 3,
                       130, 255, 255, 125, 125, 127, 0, 0, 100};
  bit lit_hit [NLIT];

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("out", dut_out, s2.val);
      check("out_valid", out_valid, s2.v);
      check("wrap", wrap, m_wrap);
      check("cfg_ready", cfg_ready, !m_pend);
      if (s2.v) begin
        for (int i = 0; i < NLIT; i++) begin
          if (s2.func == lit_f[i] && s2.amp == lit_a[i] && s2.p == lit_p[i]) begin
            check($sformatf("literal[%0d]", i), dut_out, lit_v[i]);
            lit_hit[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (cfg_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (cfg_ready !== 1'b1) fail_now(name);
  endtask

  task automatic wait_phase(input int p);
    int t = 0;
    while ((m_acc / 256) != p && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if ((m_acc / 256) != p) fail_now("wait_phase");
  endtask

  task automatic offer(input int f, input int ftw, input int amp);
    wait_ready("offer_ready");
    cfg_valid = 1'b1;
    cfg_func  = 3'(f);
    cfg_ftw   = 16'(ftw);
    cfg_amp   = 8'(amp);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  int a, b, nhit;

  initial begin
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_func = '0; cfg_ftw = '0; cfg_amp = '0;
    cycles(3);
    reset = 1'b0;
    check("rst_out", dut_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_wrap", wrap, 0);

    // Saw sweep with the config applied while idle.
    offer(0, 16'h0100, 8'hFF);
    wait_ready("saw_apply");
    en = 1'b1;
    cycles(520);

    // Offer mid-period, then a second offer that must be ignored while pending.
    wait_phase(50);
    offer(0, 16'h0200, 8'hFF);
    cfg_valid = 1'b1; cfg_func = 3'd1; cfg_ftw = 16'h0300; cfg_amp = 8'h10;
    for (int i = 0; i < 5; i++) begin
      check("pending_ready_low", cfg_ready, 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    wait_ready("ftw2_apply");
    cycles(4);
    a = int'(dut_out);
    cycles(1);
    b = int'(dut_out);
    check("step_after_apply", (b - a) & 255, 2);

    // Each shape at ftw 0x100, applied at a wrap.
    offer(2, 16'h0100, 8'hFF); wait_ready("tri_apply");   cycles(300);
    offer(3, 16'h0100, 8'hFF); wait_ready("trap_apply");  cycles(300);
    offer(4, 16'h0100, 8'hFF); wait_ready("sine_apply");  cycles(300);
    offer(1, 16'h0100, 8'h7F); wait_ready("sq_apply");    cycles(300);
    offer(0, 16'h0100, 8'h00); wait_ready("saw0_apply");  cycles(300);

    // With en low, the config lands on the very next edge.
    en = 1'b0;
    cycles(2);
    offer(2, 16'h0100, 8'h80);
    check("en0_pending", cfg_ready, 0);
    @(negedge clk);
    check("en0_applied", cfg_ready, 1);
    cycles(5);
    en = 1'b1;
    cycles(20);

    // Random traffic, including the occasional reset.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_func  = 3'($urandom_range(0, 7));
      cfg_ftw   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      cfg_amp   = 8'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; cfg_valid = 1'b0; en = 1'b0;
    cycles(2);

    // Reset mid-sweep with a pending config that must be dropped.
    offer(0, 16'h0100, 8'hFF);
    wait_ready("sweep_apply");
    en = 1'b1;
    wait_phase(95);
    offer(1, 16'h0300, 8'h40);
    check("sweep_pending", cfg_ready, 0);
    wait_phase(100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out", dut_out, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cfg_ready", cfg_ready, 1);
    cycles(20);
    check("midrst_ftw_zero", dut_out, 0);

    nhit = 0;
    for (int i = 0; i < NLIT; i++) if (lit_hit[i]) nhit++;
    check("literal_cover", nhit, NLIT);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
